// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: frame width, idle fill byte and FSM
// state encoding. Imported by spi_slave and spi_slave_sync.
package spi_slave_pkg;

   localparam int         SPI_WIDTH     = 8;
   localparam logic [7:0] SPI_IDLE_FILL = 8'h00;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Resynchroniser for one asynchronous SPI pin.
//   clock_in : system clock
//   reset    : synchronous active-high reset
//   din_i    : asynchronous pin
//   level_o  : synchronised level (last synchroniser stage)
//   rise_o   : one-cycle pulse on a synchronised 0->1 transition
//   fall_o   : one-cycle pulse on a synchronised 1->0 transition
// The edge pulses are valid STAGES cycles after the pin changes, so logic
// registering them acts STAGES+1 cycles after the pin. STAGES must be >= 2.
module spi_slave_sync
   import spi_slave_pkg::*;
#(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clock_in,
   input  logic reset,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clock_in) begin
      if (reset) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, one WIDTH-bit frame per WIDTH sclk periods.
// CPU side: load/datain fill a one-entry tx buffer; dataout/rx_valid hold the
// last complete frame, unload acknowledges it. overrun is sticky until unload.
// Serial side: sclk/ssn/mosi are asynchronous and resynchronised internally;
// miso is driven only while selected (miso_oe).
//   clock_in, reset                 : system clock, synchronous active-high reset
//   load, unload, datain            : CPU strobes and tx byte
//   dataout, rx_valid, tx_ready,
//   overrun, busy                   : CPU-side status
//   sclk, ssn, mosi, miso, miso_oe  : SPI pins
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int               WIDTH       = SPI_WIDTH,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] IDLE_FILL   = SPI_IDLE_FILL
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             load,
   input  logic             unload,
   input  logic [WIDTH-1:0] datain,
   output logic [WIDTH-1:0] dataout,
   output logic             rx_valid,
   output logic             tx_ready,
   output logic             overrun,
   output logic             busy,
   input  logic             sclk,
   input  logic             ssn,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic ssn_lvl, ssn_rise, ssn_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clock_in(clock_in), .reset(reset), .din_i(sclk),
      .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   // ssn idles high, so its synchroniser resets high to avoid a false select.
   spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssn (
      .clock_in(clock_in), .reset(reset), .din_i(ssn),
      .level_o(ssn_lvl), .rise_o(ssn_rise), .fall_o(ssn_fall)
   );

   spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clock_in(clock_in), .reset(reset), .din_i(mosi),
      .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
   );

   logic sync_unused;
   assign sync_unused = ^{sclk_lvl, mosi_rise, mosi_fall};

   spi_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
   logic [WIDTH-1:0] dataout_q, dataout_d;
   logic             tx_ready_q, tx_ready_d;
   logic             rx_valid_q, rx_valid_d;
   logic             overrun_q, overrun_d;
   logic             busy_q, busy_d;
   logic             miso_q, miso_d;
   logic             miso_oe_q, miso_oe_d;

   // Byte handed to the tx shifter whenever a frame starts or a byte boundary
   // is crossed: the buffered byte if one is pending, otherwise the fill value.
   logic [WIDTH-1:0] tx_next;
   assign tx_next = tx_ready_q ? IDLE_FILL : tx_buf_q;

   always_comb begin
      logic consume;
      logic frame_done;
      state_d    = state_q;
      count_d    = count_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      tx_buf_d   = tx_buf_q;
      dataout_d  = dataout_q;
      tx_ready_d = tx_ready_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
      busy_d     = busy_q;
      miso_d     = miso_q;
      miso_oe_d  = miso_oe_q;
      consume    = 1'b0;
      frame_done = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ssn_fall) begin
               state_d   = ST_SHIFT;
               consume   = 1'b1;
               tx_sh_d   = tx_next;
               miso_d    = tx_next[WIDTH-1];
               miso_oe_d = 1'b1;
               busy_d    = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (ssn_rise) begin
               // Deselect aborts any partial frame; received data is untouched.
               state_d   = ST_IDLE;
               count_d   = '0;
               miso_oe_d = 1'b0;
               busy_d    = 1'b0;
            end else if (!ssn_lvl && sclk_rise) begin
               rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_lvl};
               if (count_q == CNT_LAST) begin
                  count_d    = '0;
                  frame_done = 1'b1;
                  dataout_d  = {rx_sh_q[WIDTH-2:0], mosi_lvl};
                  rx_valid_d = 1'b1;
                  if (rx_valid_q && !unload) begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  count_d = count_q + 1'b1;
               end
            end else if (!ssn_lvl && sclk_fall) begin
               if (count_q != '0) begin
                  tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                  miso_d  = tx_sh_q[WIDTH-2];
               end else begin
                  // Byte boundary: start the next byte of a back-to-back burst.
                  consume = 1'b1;
                  tx_sh_d = tx_next;
                  miso_d  = tx_next[WIDTH-1];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A completing frame wins over unload so the fresh byte is not lost.
      if (unload && !frame_done) begin
         rx_valid_d = 1'b0;
         overrun_d  = 1'b0;
      end

      // load is applied after consume: the shifter took the old byte above,
      // the new byte stays pending.
      if (consume) begin
         tx_ready_d = 1'b1;
      end
      if (load) begin
         tx_buf_d   = datain;
         tx_ready_d = 1'b0;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         tx_buf_q   <= '0;
         dataout_q  <= '0;
         tx_ready_q <= 1'b1;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         busy_q     <= 1'b0;
         miso_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         tx_buf_q   <= tx_buf_d;
         dataout_q  <= dataout_d;
         tx_ready_q <= tx_ready_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         busy_q     <= busy_d;
         miso_q     <= miso_d;
         miso_oe_q  <= miso_oe_d;
      end
   end

   assign dataout  = dataout_q;
   assign rx_valid = rx_valid_q;
   assign tx_ready = tx_ready_q;
   assign overrun  = overrun_q;
   assign busy     = busy_q;
   assign miso     = miso_q;
   assign miso_oe  = miso_oe_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as SPI master (sclk period 16 clocks)
// and CPU, with expected miso/rx bytes queued as stimulus is issued.
module tb_spi_slave;

   localparam int SYNC = 2;
   localparam int HALF = 8;

   logic       clock_in = 1'b0;
   logic       reset    = 1'b1;
   logic       load     = 1'b0;
   logic       unload   = 1'b0;
   logic [7:0] datain   = 8'h00;
   logic [7:0] dataout;
   logic       rx_valid, tx_ready, overrun, busy;
   logic       sclk = 1'b0;
   logic       ssn  = 1'b1;
   logic       mosi = 1'b0;
   logic       miso, miso_oe;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_miso_q[$];
   logic [7:0] exp_rx_q[$];

   always #5 clock_in = ~clock_in;

   spi_slave dut (
      .clock_in(clock_in), .reset(reset), .load(load), .unload(unload),
      .datain(datain), .dataout(dataout), .rx_valid(rx_valid),
      .tx_ready(tx_ready), .overrun(overrun), .busy(busy),
      .sclk(sclk), .ssn(ssn), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-22s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic cpu_load(input logic [7:0] v);
      load = 1'b1; datain = v;
      @(negedge clock_in);
      load = 1'b0;
   endtask

   task automatic cpu_unload();
      unload = 1'b1;
      @(negedge clock_in);
      unload = 1'b0;
   endtask

   task automatic begin_frame();
      ssn = 1'b0;
      repeat (HALF) @(negedge clock_in);
   endtask

   task automatic end_frame();
      ssn = 1'b1;
      repeat (HALF) @(negedge clock_in);
   endtask

   // Shift nbits of tx_byte out on mosi, sampling miso just before each rise.
   // Optionally pulse load at the start of bit load_bit, and pulse unload in
   // the exact cycle the last rising edge is acted on.
   task automatic xfer(input logic [7:0] tx_byte, input int nbits,
                       input int load_bit, input logic [7:0] load_val,
                       input bit unload_last, output logic [7:0] got);
      got = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx_byte[7-i];
         if (i == load_bit) begin
            cpu_load(load_val);
            repeat (HALF - 1) @(negedge clock_in);
         end else begin
            repeat (HALF) @(negedge clock_in);
         end
         got[7-i] = miso;
         sclk = 1'b1;
         if (unload_last && i == nbits - 1) begin
            repeat (SYNC) @(negedge clock_in);
            cpu_unload();
            repeat (HALF - SYNC - 1) @(negedge clock_in);
         end else begin
            repeat (HALF) @(negedge clock_in);
         end
         sclk = 1'b0;
      end
      repeat (HALF) @(negedge clock_in);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit expired");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] got;
      logic [7:0] last_rx;

      // Reset
      repeat (2) @(negedge clock_in);
      reset = 1'b0;
      @(negedge clock_in);
      check("reset_rx_valid", {7'd0, rx_valid}, 8'd0);
      check("reset_tx_ready", {7'd0, tx_ready}, 8'd1);
      check("reset_miso_oe", {7'd0, miso_oe}, 8'd0);
      check("reset_dataout", dataout, 8'h00);
      check("reset_busy_overrun", {6'd0, busy, overrun}, 8'd0);

      // Single frame: tx A5, rx 3C
      cpu_load(8'hA5);
      check("load_tx_ready", {7'd0, tx_ready}, 8'd0);
      exp_miso_q.push_back(8'hA5);
      exp_rx_q.push_back(8'h3C);
      begin_frame();
      check("frame_busy", {6'd0, busy, miso_oe}, 8'd3);
      xfer(8'h3C, 8, -1, 8'h00, 1'b0, got);
      end_frame();
      check("f1_miso", got, exp_miso_q.pop_front());
      check("f1_dataout", dataout, exp_rx_q.pop_front());
      check("f1_rxv_txr", {6'd0, rx_valid, tx_ready}, 8'd3);
      check("f1_idle_busy_oe", {6'd0, busy, miso_oe}, 8'd0);
      cpu_unload();
      check("f1_unload_rxv", {7'd0, rx_valid}, 8'd0);

      // Two back-to-back frames, second tx byte loaded mid-frame
      cpu_load(8'h81);
      exp_miso_q.push_back(8'h81);
      exp_miso_q.push_back(8'h7E);
      exp_rx_q.push_back(8'h11);
      exp_rx_q.push_back(8'h22);
      begin_frame();
      xfer(8'h11, 8, 3, 8'h7E, 1'b0, got);
      check("b2b_miso1", got, exp_miso_q.pop_front());
      check("b2b_dataout1", dataout, exp_rx_q.pop_front());
      check("b2b_ovr1", {6'd0, rx_valid, overrun}, 8'd2);
      xfer(8'h22, 8, -1, 8'h00, 1'b0, got);
      end_frame();
      check("b2b_miso2", got, exp_miso_q.pop_front());
      check("b2b_dataout2", dataout, exp_rx_q.pop_front());
      check("b2b_overrun", {6'd0, rx_valid, overrun}, 8'd3);
      cpu_unload();
      check("b2b_unload_clear", {6'd0, rx_valid, overrun}, 8'd0);

      // No load: idle fill on miso
      exp_miso_q.push_back(8'h00);
      exp_rx_q.push_back(8'h5A);
      begin_frame();
      xfer(8'h5A, 8, -1, 8'h00, 1'b0, got);
      end_frame();
      check("fill_miso", got, exp_miso_q.pop_front());
      last_rx = exp_rx_q.pop_front();
      check("fill_dataout", dataout, last_rx);

      // Partial frame aborted after 5 bits
      begin_frame();
      xfer(8'hC3, 5, -1, 8'h00, 1'b0, got);
      check("part_busy_mid", {6'd0, busy, miso_oe}, 8'd3);
      end_frame();
      check("part_busy_oe", {6'd0, busy, miso_oe}, 8'd0);
      check("part_rx_valid", {7'd0, rx_valid}, 8'd1);
      check("part_dataout", dataout, last_rx);
      exp_rx_q.push_back(8'hF0);
      begin_frame();
      xfer(8'hF0, 8, -1, 8'h00, 1'b0, got);
      end_frame();
      check("after_part_dataout", dataout, exp_rx_q.pop_front());
      check("after_part_overrun", {7'd0, overrun}, 8'd1);
      cpu_unload();

      // unload coinciding with frame completion
      exp_rx_q.push_back(8'h66);
      exp_rx_q.push_back(8'h99);
      begin_frame();
      xfer(8'h66, 8, -1, 8'h00, 1'b0, got);
      check("unl_pre_dataout", dataout, exp_rx_q.pop_front());
      xfer(8'h99, 8, -1, 8'h00, 1'b1, got);
      end_frame();
      check("unl_same_dataout", dataout, exp_rx_q.pop_front());
      check("unl_same_rxv_ovr", {6'd0, rx_valid, overrun}, 8'd2);

      // Reset mid-frame
      cpu_load(8'h33);
      begin_frame();
      xfer(8'hAA, 4, -1, 8'h00, 1'b0, got);
      check("mid_busy", {7'd0, busy}, 8'd1);
      reset = 1'b1; ssn = 1'b1; sclk = 1'b0;
      @(negedge clock_in);
      check("rst_mid_dataout", dataout, 8'h00);
      check("rst_mid_flags",
            {1'b0, rx_valid, tx_ready, overrun, busy, miso, miso_oe, 1'b0}, 8'h20);
      reset = 1'b0;
      repeat (HALF) @(negedge clock_in);
      check("rst_mid_settled", {6'd0, busy, tx_ready}, 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
